regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: DEPTH, default 4, number of entries in the multicycle-result FIFO (power of two, 2..16).
REQ-002 Parameter: STARVE_LIMIT, default 3, number of consecutive cycles a FIFO head may lose arbitration before a stall is requested.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: p_valid  input  1  pipeline WB-stage result valid; always accepted, no backpressure.
REQ-006 Port: p_addr  input  5  pipeline destination register.
REQ-007 Port: p_data  input  32  pipeline result.
REQ-008 Port: m_valid  input  1  multicycle (mul/div) unit result valid.
REQ-009 Port: m_ready  output  1  FIFO can accept a multicycle result this cycle.
REQ-010 Port: m_addr  input  5  multicycle destination register.
REQ-011 Port: m_data  input  32  multicycle result.
REQ-012 Port: sb_set  input  1  decode has issued a multicycle op with destination sb_addr.
REQ-013 Port: sb_addr  input  5  destination being marked outstanding.
REQ-014 Port: q_addr1 and q_addr2  input  5 each  decode source/dest query addresses.
REQ-015 Port: q_busy1 and q_busy2  output  1 each  queried register has an outstanding multicycle write.
REQ-016 Port: wb_en, wb_addr, wb_data  output  1/5/32  register-file write port drive.
REQ-017 Port: stall_req  output  1  request for the pipeline to insert a WB bubble.
REQ-018 Port: sb_err  output  1  sticky scoreboard overflow or underflow flag.

Function
REQ-019 A multicycle handshake SHALL complete when m_valid and m_ready are both high at a rising edge; the entry is then pushed to the FIFO tail.
REQ-020 m_ready SHALL be high exactly when the registered FIFO occupancy is less than DEPTH; a pop in the same cycle SHALL NOT raise m_ready while the FIFO is full.
REQ-021 Arbitration per cycle: p_valid wins; otherwise the FIFO head, when non-empty, wins and is popped at that edge.
REQ-022 wb_en/wb_addr/wb_data SHALL be registered: a winner selected in cycle N appears on the outputs in cycle N+1 for exactly one cycle.
REQ-023 Latency: p_valid at cycle N gives wb_en at N+1; an m handshake at edge N with an empty FIFO and no p_valid at N+1 gives wb_en at N+2.
REQ-024 A winner with address 0 SHALL be consumed (popped if from the FIFO) but SHALL produce wb_en=0; wb_addr/wb_data hold their previous values.
REQ-025 Starvation counter: increments each cycle the FIFO is non-empty and p_valid=1; clears on any FIFO pop or when the FIFO is empty; stall_req=1 while counter >= STARVE_LIMIT.
REQ-026 Scoreboard: one 3-bit counter per register 1..31; sb_set increments the counter; a FIFO-sourced write (wb_en from a FIFO pop) decrements it; both in the same cycle on the same register leave it unchanged.
REQ-027 sb_set on a counter at 7, or a FIFO write decrement on a counter at 0, SHALL leave the counter unchanged and set sb_err; sb_set with sb_addr=0 SHALL be ignored.
REQ-028 q_busyN SHALL be combinational: 1 iff counter[q_addrN] != 0; q_addr=0 gives 0.
REQ-029 The decoder stalls on busy sources and destinations, so no pipeline write targets a register with a nonzero counter; the block does not reorder writes.

Reset
REQ-030 While rst_n=0: FIFO empty, m_ready=0, wb_en=0, wb_addr=0, wb_data=0, stall_req=0, all counters 0, sb_err=0; m_ready rises on the first clock edge after release.
REQ-031 Reset asserted mid-operation SHALL discard all FIFO entries and outstanding scoreboard state without emitting any write.

Verification
REQ-032 p_valid=1, p_addr=5, p_data=0x1234 at cycle 10 -> wb_en=1, wb_addr=5, wb_data=0x1234 in cycle 11 only.
REQ-033 sb_set addr 9, then m handshake addr 9 data 0xBEEF with the pipeline idle -> q_busy1(q_addr1=9)=1 until the wb_en cycle; wb_en two cycles after the handshake; q_busy1 reads 0 the cycle after the write.
REQ-034 Push 4 m results with DEPTH=4 while p_valid=1 continuously -> m_ready=0 after the 4th; stall_req=1 from the 3rd contended cycle; p_valid dropped -> FIFO drains in order, one write per cycle.
REQ-035 p_valid addr 0 and m result addr 0 -> no wb_en; the FIFO entry is popped; m_ready recovers.
REQ-036 sb_set addr 3 and FIFO write addr 3 in the same cycle with counter=1 -> counter stays 1; 8 consecutive sb_set on addr 4 -> sb_err=1, counter=7.
REQ-037 rst_n pulled low with 3 FIFO entries and busy counters set -> all outputs at reset values immediately; no wb_en after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: merges pipeline results with a FIFO of multicycle results onto
// the single register-file write port, and tracks outstanding multicycle destinations.
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_valid,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_data,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_addr,
    input  logic [31:0] m_data,
    input  logic        sb_set,
    input  logic [4:0]  sb_addr,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        q_busy1,
    output logic        q_busy2,
    output logic        wb_en,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        stall_req,
    output logic        sb_err
);

    localparam int AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;
    logic          win_valid;
    logic [4:0]    win_addr;
    logic [31:0]   win_data;
    logic          wb_from_fifo;
    logic [SW-1:0] starve_cnt;
    logic [2:0]    sb_cnt [32];
    logic [31:0]   sb_inc;
    logic [31:0]   sb_dec;
    logic          sb_fault;

    // m_ready is a registered view of occupancy, so a pop while full cannot open it early
    assign push       = m_valid && m_ready;
    assign pop        = !p_valid && (count != '0);
    assign count_next = count + CW'(push) - CW'(pop);

    assign win_valid = p_valid || (count != '0);
    assign win_addr  = p_valid ? p_addr : fifo_addr[rd_ptr];
    assign win_data  = p_valid ? p_data : fifo_data[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= m_addr;
            fifo_data[wr_ptr] <= m_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            m_ready <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_next;
            m_ready <= (count_next < FULL_CNT);
        end
    end

    // Address-0 winners are consumed silently; the data outputs keep their last write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en        <= 1'b0;
            wb_addr      <= '0;
            wb_data      <= '0;
            wb_from_fifo <= 1'b0;
        end else if (win_valid && (win_addr != 5'd0)) begin
            wb_en        <= 1'b1;
            wb_addr      <= win_addr;
            wb_data      <= win_data;
            wb_from_fifo <= pop;
        end else begin
            wb_en        <= 1'b0;
            wb_from_fifo <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if ((count == '0) || pop) begin
            starve_cnt <= '0;
        end else if (p_valid && (starve_cnt < STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    assign stall_req = (starve_cnt >= STARVE_MAX);

    // The decrement lands at the end of the write cycle, when the register file takes the value
    always_comb begin
        sb_inc = '0;
        sb_dec = '0;
        if (sb_set && (sb_addr != 5'd0)) sb_inc[sb_addr] = 1'b1;
        if (wb_from_fifo && (wb_addr != 5'd0)) sb_dec[wb_addr] = 1'b1;
    end

    always_comb begin
        sb_fault = 1'b0;
        for (int i = 1; i < 32; i++) begin
            if (sb_inc[i] && !sb_dec[i] && (sb_cnt[i] == 3'd7)) sb_fault = 1'b1;
            if (sb_dec[i] && !sb_inc[i] && (sb_cnt[i] == 3'd0)) sb_fault = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) sb_cnt[i] <= 3'd0;
            sb_err <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (sb_inc[i] && !sb_dec[i] && (sb_cnt[i] != 3'd7)) begin
                    sb_cnt[i] <= sb_cnt[i] + 3'd1;
                end else if (sb_dec[i] && !sb_inc[i] && (sb_cnt[i] != 3'd0)) begin
                    sb_cnt[i] <= sb_cnt[i] - 3'd1;
                end
            end
            if (sb_fault) sb_err <= 1'b1;
        end
    end

    assign q_busy1 = (sb_cnt[q_addr1] != 3'd0);
    assign q_busy2 = (sb_cnt[q_addr2] != 3'd0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized and directed bench for regfile_wb_arbiter, checked cycle by cycle against
// a queue/array reference model of the write-back rules.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        clk;
    logic        rst_n;
    logic        p_valid;
    logic [4:0]  p_addr;
    logic [31:0] p_data;
    logic        m_valid;
    logic        m_ready;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        q_busy1;
    logic        q_busy2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall_req;
    logic        sb_err;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_data(m_data),
        .sb_set(sb_set), .sb_addr(sb_addr),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .stall_req(stall_req), .sb_err(sb_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    int checks;
    int failures;

    // reference model state
    ent_t        mq[$];
    int          sbm[32];
    bit          merr;
    int          mstarve;
    bit          malive;
    logic        men;
    logic [4:0]  maddr;
    logic [31:0] mdata;
    bit          msrc;
    bit          hs_last;
    logic [4:0]  pend[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 32; i++) sbm[i] = 0;
        merr    = 0;
        mstarve = 0;
        malive  = 0;
        men     = 1'b0;
        maddr   = '0;
        mdata   = '0;
        msrc    = 0;
        hs_last = 0;
    endtask

    task automatic model_update();
        ent_t w;
        bit   have_w;
        bit   from_fifo;
        bit   push;
        int   n0;
        int   inc_a;
        int   dec_a;
        n0        = mq.size();
        push      = m_valid && malive && (n0 < DEPTH);
        have_w    = 0;
        from_fifo = 0;
        w.a       = '0;
        w.d       = '0;
        if (p_valid) begin
            have_w = 1;
            w.a    = p_addr;
            w.d    = p_data;
        end else if (n0 > 0) begin
            have_w    = 1;
            w         = mq.pop_front();
            from_fifo = 1;
        end
        inc_a = sb_set ? int'(sb_addr) : 0;
        dec_a = (men && msrc) ? int'(maddr) : 0;
        if (!(inc_a != 0 && inc_a == dec_a)) begin
            if (inc_a != 0) begin
                if (sbm[inc_a] == 7) merr = 1;
                else sbm[inc_a]++;
            end
            if (dec_a != 0) begin
                if (sbm[dec_a] == 0) merr = 1;
                else sbm[dec_a]--;
            end
        end
        if (n0 == 0 || from_fifo) mstarve = 0;
        else if (p_valid) mstarve++;
        if (push) begin
            ent_t e;
            e.a = m_addr;
            e.d = m_data;
            mq.push_back(e);
        end
        if (have_w && w.a != 5'd0) begin
            men   = 1'b1;
            maddr = w.a;
            mdata = w.d;
            msrc  = from_fifo;
        end else begin
            men  = 1'b0;
            msrc = 0;
        end
        malive  = 1;
        hs_last = push;
    endtask

    task automatic check_regs();
        chk("wb_en", 32'(wb_en), 32'(men));
        chk("wb_addr", 32'(wb_addr), 32'(maddr));
        chk("wb_data", wb_data, mdata);
        chk("m_ready", 32'(m_ready), 32'(malive && (mq.size() < DEPTH)));
        chk("stall_req", 32'(stall_req), 32'(mstarve >= LIMIT));
        chk("sb_err", 32'(sb_err), 32'(merr));
    endtask

    task automatic check_busy();
        chk("q_busy1", 32'(q_busy1), 32'(sbm[q_addr1] != 0));
        chk("q_busy2", 32'(q_busy2), 32'(sbm[q_addr2] != 0));
    endtask

    task automatic cycle();
        #1 check_busy();
        @(posedge clk);
        model_update();
        #1 check_regs();
    endtask

    task automatic idle();
        p_valid = 1'b0; p_addr = '0; p_data = '0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        sb_set  = 1'b0; sb_addr = '0;
        q_addr1 = '0;   q_addr2 = '0;
    endtask

    task automatic apply_reset(input int cyc);
        rst_n = 1'b0;
        model_reset();
        pend.delete();
        #1 check_regs();
        check_busy();
        repeat (cyc) @(posedge clk);
        #3 check_regs();
        idle();
        rst_n = 1'b1;
    endtask

    task automatic rand_inputs(input int pv_pct);
        p_valid = ($urandom_range(0, 99) < pv_pct);
        p_addr  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        p_data  = $urandom();
        sb_set  = ($urandom_range(0, 3) == 0) && (pend.size() < 6);
        sb_addr = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        if (sb_set && sb_addr != 5'd0) pend.push_back(sb_addr);
        m_valid = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
        m_addr  = m_valid ? pend[0] : 5'($urandom_range(0, 31));
        m_data  = $urandom();
        if (pend.size() > 0 && $urandom_range(0, 1) == 1)
            q_addr1 = pend[$urandom_range(0, pend.size() - 1)];
        else
            q_addr1 = 5'($urandom_range(0, 31));
        q_addr2 = 5'($urandom_range(0, 31));
    endtask

    task automatic rand_phase(input int n, input int pv_pct);
        for (int k = 0; k < n; k++) begin
            rand_inputs(pv_pct);
            cycle();
            if (hs_last && pend.size() > 0) void'(pend.pop_front());
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rst_n = 1'b1;
        #2;
        apply_reset(3);

        // single pipeline write, one cycle only, outputs hold afterwards
        repeat (8) cycle();
        p_valid = 1'b1; p_addr = 5'd5; p_data = 32'h1234;
        cycle();
        idle();
        chk("p_wb_en", 32'(wb_en), 32'd1);
        chk("p_wb_addr", 32'(wb_addr), 32'd5);
        chk("p_wb_data", wb_data, 32'h1234);
        cycle();
        chk("p_wb_en_once", 32'(wb_en), 32'd0);
        chk("p_wb_hold", 32'(wb_addr), 32'd5);

        // scoreboarded multicycle result
        sb_set = 1'b1; sb_addr = 5'd9; q_addr1 = 5'd9;
        cycle();
        sb_set = 1'b0;
        m_valid = 1'b1; m_addr = 5'd9; m_data = 32'hBEEF;
        cycle();
        m_valid = 1'b0;
        chk("m_lat_n1", 32'(wb_en), 32'd0);
        #1 chk("busy_pending", 32'(q_busy1), 32'd1);
        cycle();
        chk("m_lat_n2", 32'(wb_en), 32'd1);
        chk("m_data", wb_data, 32'hBEEF);
        #1 chk("busy_in_wb", 32'(q_busy1), 32'd1);
        cycle();
        #1 chk("busy_cleared", 32'(q_busy1), 32'd0);
        idle();

        // fill FIFO under continuous pipeline traffic, then drain
        for (int k = 0; k < 4; k++) begin
            sb_set = 1'b1; sb_addr = 5'(10 + k);
            cycle();
        end
        idle();
        p_valid = 1'b1; p_addr = 5'd20;
        for (int k = 0; k < 4; k++) begin
            p_data  = 32'($urandom());
            m_valid = 1'b1; m_addr = 5'(10 + k); m_data = 32'h100 + 32'(k);
            cycle();
        end
        m_valid = 1'b0;
        chk("full_m_ready", 32'(m_ready), 32'd0);
        chk("starve_stall", 32'(stall_req), 32'd1);
        cycle();
        chk("full_m_ready2", 32'(m_ready), 32'd0);
        p_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("drain_en", 32'(wb_en), 32'd1);
            chk("drain_addr", 32'(wb_addr), 32'(10 + k));
            chk("drain_data", wb_data, 32'h100 + 32'(k));
        end
        cycle();
        chk("drain_ready", 32'(m_ready), 32'd1);
        chk("drain_stall", 32'(stall_req), 32'd0);

        // address 0 from both sources
        p_valid = 1'b1; p_addr = 5'd0; p_data = 32'hDEAD;
        m_valid = 1'b1; m_addr = 5'd0; m_data = 32'hCAFE;
        cycle();
        idle();
        chk("zero_p", 32'(wb_en), 32'd0);
        cycle();
        chk("zero_m", 32'(wb_en), 32'd0);
        cycle();
        chk("zero_ready", 32'(m_ready), 32'd1);

        // underflow: FIFO write to a register never marked
        m_valid = 1'b1; m_addr = 5'd6; m_data = 32'h66;
        cycle();
        idle();
        repeat (2) cycle();
        chk("sb_underflow", 32'(sb_err), 32'd1);
        apply_reset(2);

        // simultaneous set and write on the same register
        sb_set = 1'b1; sb_addr = 5'd3;
        cycle();
        idle();
        m_valid = 1'b1; m_addr = 5'd3; m_data = 32'h33;
        cycle();
        idle();
        cycle();
        chk("same_wb", 32'(wb_en), 32'd1);
        sb_set = 1'b1; sb_addr = 5'd3;
        cycle();
        idle();
        q_addr1 = 5'd3;
        cycle();
        #1 chk("same_cycle_busy", 32'(q_busy1), 32'd1);
        chk("same_cycle_err", 32'(sb_err), 32'd0);

        // overflow
        for (int k = 0; k < 8; k++) begin
            sb_set = 1'b1; sb_addr = 5'd4; q_addr2 = 5'd4;
            cycle();
        end
        idle();
        q_addr2 = 5'd4;
        chk("sb_overflow", 32'(sb_err), 32'd1);
        #1 chk("ovf_busy", 32'(q_busy2), 32'd1);
        apply_reset(2);

        // reset with FIFO entries and busy counters
        for (int k = 0; k < 3; k++) begin
            sb_set = 1'b1; sb_addr = 5'(15 + k);
            cycle();
        end
        idle();
        p_valid = 1'b1; p_addr = 5'd21;
        for (int k = 0; k < 3; k++) begin
            m_valid = 1'b1; m_addr = 5'(15 + k); m_data = 32'h500 + 32'(k);
            cycle();
        end
        idle();
        q_addr1 = 5'd15;
        apply_reset(2);
        q_addr1 = 5'd15;
        #1 chk("rst_busy", 32'(q_busy1), 32'd0);
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rst_no_wb", 32'(wb_en), 32'd0);
        end

        rand_phase(800, 50);
        rand_phase(600, 85);
        apply_reset(1);
        rand_phase(600, 30);
        rand_inputs(70);
        #3 apply_reset(1);
        rand_phase(300, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
